// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the scanner state encoding, matrix dimensions and key-code packing.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    REPORT   = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  function automatic logic [KEY_W-1:0] pack_key(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Highest set column wins; an all-zero input maps to column 0.
  function automatic logic [1:0] top_col(input logic [NUM_COLS-1:0] cols);
    logic [1:0] c;
    c = 2'd0;
    if (cols[3])      c = 2'd3;
    else if (cols[2]) c = 2'd2;
    else if (cols[1]) c = 2'd1;
    return c;
  endfunction

endpackage

// File: rtl/keypad_scanner_decoder.sv
// Generic 2-to-4 one-hot decoder with enable, used to drive the keypad rows.
module decoder_2to4 (
  input  logic       i_en,
  input  logic [1:0] i_sel,
  output logic [3:0] o_y
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_out
    assign o_y[gi] = i_en && (i_sel == 2'(gi));
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the rows, debounces the first key found
// and reports it once with a one-cycle strobe, then waits for its release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  state_e              r_state;
  logic [1:0]          r_row;
  logic [1:0]          r_col;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DEB_W-1:0]    r_deb_cnt;
  logic [NUM_COLS-1:0] r_sync1;
  logic [NUM_COLS-1:0] r_col_s;
  logic [KEY_W-1:0]    r_key_code;
  logic                r_key_valid;
  logic                r_key_held;
  logic                w_key_line;

  assign w_key_line = r_col_s[r_col];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_row       <= 2'd0;
      r_col       <= 2'd0;
      r_div_cnt   <= '0;
      r_deb_cnt   <= '0;
      r_sync1     <= '0;
      r_col_s     <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_sync1     <= col_in;
      r_col_s     <= r_sync1;
      r_key_valid <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_div_cnt == DIV_LAST) begin
            r_div_cnt <= '0;
            if (r_col_s != '0) begin
              r_col     <= top_col(r_col_s);
              r_deb_cnt <= '0;
              r_state   <= DEBOUNCE;
            end else begin
              r_row <= r_row + 2'd1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        DEBOUNCE: begin
          if (w_key_line) begin
            // Strobe and code are registered on entry so they are visible in REPORT.
            if (r_deb_cnt == DEB_LAST) begin
              r_key_valid <= 1'b1;
              r_key_code  <= pack_key(r_row, r_col);
              r_key_held  <= 1'b1;
              r_state     <= REPORT;
            end else begin
              r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
          end else begin
            r_row     <= r_row + 2'd1;
            r_div_cnt <= '0;
            r_state   <= SCAN;
          end
        end
        REPORT: begin
          r_deb_cnt <= '0;
          r_state   <= RELEASE;
        end
        RELEASE: begin
          if (!w_key_line) begin
            if (r_deb_cnt == DEB_LAST) begin
              r_key_held <= 1'b0;
              r_row      <= r_row + 2'd1;
              r_div_cnt  <= '0;
              r_deb_cnt  <= '0;
              r_state    <= SCAN;
            end else begin
              r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
          end else begin
            r_deb_cnt <= '0;
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  decoder_2to4 u_row_dec (
    .i_en  (1'b1),
    .i_sel (r_row),
    .o_y   (row_out)
  );

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix, directed scenarios with
// hand-computed timing, and random key activity checked every cycle against a model.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = 16'h0;   // bit r*4+c = key at row r, column c is down
  logic [3:0]  glitch  = 4'h0;    // forced onto the column lines regardless of row

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always_comb begin
    col_in = glitch;
    for (int r = 0; r < 4; r++)
      if (row_out[r]) col_in = col_in | pressed[r*4 +: 4];
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The scanner dwells SCAN_DIV cycles per row and looks at the synchronised
  // columns at the end of the dwell; a found key must then stay down for DEB
  // cycles to be reported, and must stay up for DEB consecutive cycles to be released.
  localparam int M_SCAN = 0, M_CONFIRM = 1, M_SHOW = 2, M_WAITUP = 3;
  int         m_row = 0, m_dwell = 0, m_mode = M_SCAN, m_col = 0, m_run = 0;
  logic [3:0] m_pipe0 = 4'h0, m_pipe1 = 4'h0, sample_col = 4'h0;
  int         exp_valid = 0, exp_code = 0, exp_held = 0;

  function automatic int highest(input logic [3:0] v);
    for (int i = 3; i >= 0; i--)
      if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    logic [3:0] cs;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_row = 0; m_dwell = 0; m_mode = M_SCAN; m_col = 0; m_run = 0;
        m_pipe0 = 4'h0; m_pipe1 = 4'h0;
        exp_valid = 0; exp_code = 0; exp_held = 0;
      end else begin
        cs = m_pipe1;
        m_pipe1 = m_pipe0;
        m_pipe0 = sample_col;
        exp_valid = 0;
        case (m_mode)
          M_SCAN: begin
            if (m_dwell == SCAN_DIV - 1) begin
              m_dwell = 0;
              if (cs != 4'h0) begin
                m_col = highest(cs);
                m_run = 0;
                m_mode = M_CONFIRM;
              end else m_row = (m_row + 1) % 4;
            end else m_dwell++;
          end
          M_CONFIRM: begin
            if (cs[m_col]) begin
              m_run++;
              if (m_run == DEB) begin
                m_mode = M_SHOW;
                exp_valid = 1;
                exp_code = m_row * 4 + m_col;
                exp_held = 1;
              end
            end else begin
              m_row = (m_row + 1) % 4;
              m_dwell = 0;
              m_mode = M_SCAN;
            end
          end
          M_SHOW: begin
            m_run = 0;
            m_mode = M_WAITUP;
          end
          default: begin
            if (!cs[m_col]) begin
              m_run++;
              if (m_run == DEB) begin
                exp_held = 0;
                m_row = (m_row + 1) % 4;
                m_dwell = 0;
                m_mode = M_SCAN;
              end
            end else m_run = 0;
          end
        endcase
      end
    end
  end

  // Per-cycle compare at the falling edge, then capture what the DUT will sample next.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("row_out",   int'(row_out),   1 << m_row);
        chk("key_valid", int'(key_valid), exp_valid);
        chk("key_code",  int'(key_code),  exp_code);
        chk("key_held",  int'(key_held),  exp_held);
      end
      sample_col = col_in;
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_row(input logic [3:0] want, input string name);
    int n;
    n = 0;
    while (row_out != want && n < 64) begin
      tick();
      n++;
    end
    chk(name, int'(row_out), int'(want));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!key_valid && n < 80) begin
      tick();
      n++;
    end
    chk(name, int'(key_valid), 1);
  endtask

  task automatic wait_release(input string name, output int n);
    n = 0;
    while (key_held && n < 40) begin
      tick();
      n++;
    end
    chk(name, int'(key_held), 0);
  endtask

  initial begin
    int n, pulses, got_code, got_held, seg_len, kind;

    repeat (3) tick();
    chk("rst_row",   int'(row_out),   4'b0001);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_code",  int'(key_code),  0);
    chk("rst_held",  int'(key_held),  0);
    rst_n = 1'b1;

    // Idle scan: each row held SCAN_DIV cycles, counted from reset release.
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("idle_row", int'(row_out), 1 << ((k / SCAN_DIV) % 4));
      chk("idle_valid", int'(key_valid), 0);
    end

    // Key at row 1, column 2.
    wait_row(4'b0010, "t2_wait_row1");
    pressed = 16'h0040;
    pulses = 0; got_code = -1; got_held = -1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key_valid) begin
        pulses++;
        got_code = int'(key_code);
        got_held = int'(key_held);
      end
    end
    chk("t2_pulses", pulses, 1);
    chk("t2_code", got_code, 4'b0110);
    chk("t2_held", got_held, 1);
    pressed = 16'h0;
    wait_release("t2_release", n);
    chk("t2_release_lat", n, 2 + DEB);
    chk("t2_resume_row", int'(row_out), 4'b0100);

    // Two-cycle glitch on row 3 must be rejected and cost one debounce attempt.
    wait_row(4'b1000, "t3_wait_row3");
    glitch = 4'b0001;
    tick();
    tick();
    glitch = 4'h0;
    n = 2; pulses = 0;
    while (row_out != 4'b0001 && n < 20) begin
      tick();
      n++;
      if (key_valid) pulses++;
    end
    chk("t3_resume_lat", n, 5);
    chk("t3_pulses", pulses, 0);

    // Two keys on row 0: highest column wins.
    pressed = 16'h000C;
    wait_valid("t4_valid");
    chk("t4_code", int'(key_code), 4'b0011);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (key_valid) pulses++;
    end
    chk("t4_extra_pulses", pulses, 0);
    pressed = 16'h0;
    wait_release("t4_release", n);

    // Release bounce: up, down, up must extend the hold by two cycles.
    pressed = 16'h0200;
    wait_valid("t5_valid");
    chk("t5_code", int'(key_code), 4'b1001);
    repeat (3) tick();
    pressed = 16'h0;
    tick();
    pressed = 16'h0200;
    tick();
    pressed = 16'h0;
    n = 2; pulses = 0;
    while (key_held && n < 40) begin
      tick();
      n++;
      if (key_valid) pulses++;
    end
    chk("t5_release_lat", n, 7);
    chk("t5_pulses", pulses, 0);

    // Reset while the key is held; the still-pressed key must be re-debounced.
    pressed = 16'h1000;
    wait_valid("t6_valid");
    chk("t6_code", int'(key_code), 4'b1100);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_row",   int'(row_out),   4'b0001);
    chk("t6_rst_valid", int'(key_valid), 0);
    chk("t6_rst_code",  int'(key_code),  0);
    chk("t6_rst_held",  int'(key_held),  0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    while (!key_valid && n < 40) begin
      tick();
      n++;
    end
    chk("t6_revalid_lat", n, 19);
    repeat (5) tick();
    pressed = 16'h0;
    wait_release("t6_release", n);

    // Random key activity with occasional glitches and resets.
    for (int s = 0; s < 150; s++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: pressed = 16'h0;
        1: pressed = 16'h1 << $urandom_range(0, 15);
        2: pressed = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
        default: pressed = 16'($urandom) & 16'($urandom);
      endcase
      seg_len = $urandom_range(1, 40);
      for (int k = 0; k < seg_len; k++) begin
        glitch = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
        tick();
      end
      glitch = 4'h0;
      if ($urandom_range(0, 29) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
    end
    pressed = 16'h0;
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
